// File: rtl/dsp48_dot_seq_if.sv
// Bundle between a host/control block and the dot-product sequencer: the
// request fields, operand-memory read port, DSP control/P path and result.
interface dsp48_dot_seq_if #(
   parameter int LEN_W  = 10,
   parameter int ADDR_W = 10,
   parameter int NBP    = 48
);
   // Request: start/len/base_a/base_b/sub are sampled together on a single
   // start pulse while the sequencer is idle; there is no start-side ready,
   // a start seen while busy is dropped.
   // Result: result_valid rises with result stable and both hold until the
   // cycle after result_valid & result_ready is sampled on a rising edge.
   logic              start;
   logic [LEN_W-1:0]  len;
   logic [ADDR_W-1:0] base_a;
   logic [ADDR_W-1:0] base_b;
   logic              sub;
   logic              busy;
   logic              rd_en;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [4:0]        dsp_mode;
   logic              dsp_ce1;
   logic              dsp_ce2;
   logic              dsp_cem;
   logic              dsp_cep;
   logic [NBP-1:0]    dsp_p;
   logic [NBP-1:0]    result;
   logic              result_valid;
   logic              result_ready;

   modport slave (
      input  start, len, base_a, base_b, sub, dsp_p, result_ready,
      output busy, rd_en, addr_a, addr_b, dsp_mode,
             dsp_ce1, dsp_ce2, dsp_cem, dsp_cep, result, result_valid
   );

   modport master (
      output start, len, base_a, base_b, sub, dsp_p, result_ready,
      input  busy, rd_en, addr_a, addr_b, dsp_mode,
             dsp_ce1, dsp_ce2, dsp_cem, dsp_cep, result, result_valid
   );
endinterface

// File: rtl/dsp48_dot_seq.sv
// Drives a DSP48 slice as a MAC: issues operand addresses, delays the mode so
// the first product clears the accumulator, captures final P and hands it off.
module dsp48_dot_seq #(
   parameter int LEN_W    = 10,
   parameter int ADDR_W   = 10,
   parameter int NBP      = 48,
   parameter int MODE_LAT = 1,
   parameter int DSP_LAT  = 3
) (
   input  logic                 clock,
   input  logic                 reset_n,
   dsp48_dot_seq_if.slave       bus,
   output logic [1:0]           dbg_state_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, HOLD = 2'd3} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_a_q, base_a_d;
   logic [ADDR_W-1:0] base_b_q, base_b_d;
   logic              sub_q, sub_d;
   logic [NBP-1:0]    result_q, result_d;
   logic [4:0]        mode_pipe_q [MODE_LAT+1];
   logic [4:0]        mode_issue;
   logic              issue;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         base_a_q <= '0;
         base_b_q <= '0;
         sub_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         base_a_q <= base_a_d;
         base_b_q <= base_b_d;
         sub_q    <= sub_d;
         result_q <= result_d;
      end
   end

   // cnt_q is the product index k in ISSUE and the P-latency wait in DRAIN.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      base_a_d = base_a_q;
      base_b_d = base_b_q;
      sub_d    = sub_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               len_d    = bus.len;
               base_a_d = bus.base_a;
               base_b_d = bus.base_b;
               sub_d    = bus.sub;
               cnt_d    = '0;
               if (bus.len == '0) begin
                  result_d = '0;
                  state_d  = HOLD;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (cnt_q == len_q - LEN_W'(1)) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == LEN_W'(DSP_LAT)) begin
               result_d = bus.dsp_p;
               state_d  = HOLD;
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         HOLD: begin
            if (bus.result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign issue      = (state_q == ISSUE);
   assign mode_issue = issue ? {1'b0, (cnt_q == '0) ? 2'b00 : 2'b10, sub_q ? 2'b11 : 2'b00}
                             : 5'b00000;

   // Stage 0 lines up with the operand leaving the memory; stage MODE_LAT is
   // where the slice wants its mode for that operand.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i <= MODE_LAT; i++) mode_pipe_q[i] <= '0;
      end else begin
         mode_pipe_q[0] <= mode_issue;
         for (int i = 1; i <= MODE_LAT; i++) mode_pipe_q[i] <= mode_pipe_q[i-1];
      end
   end

   assign bus.busy         = (state_q != IDLE);
   assign bus.rd_en        = issue;
   assign bus.addr_a       = issue ? base_a_q + ADDR_W'(cnt_q) : '0;
   assign bus.addr_b       = issue ? base_b_q + ADDR_W'(cnt_q) : '0;
   assign bus.dsp_mode     = mode_pipe_q[MODE_LAT];
   assign bus.dsp_ce1      = bus.busy;
   assign bus.dsp_ce2      = bus.busy;
   assign bus.dsp_cem      = bus.busy;
   assign bus.dsp_cep      = issue || (state_q == DRAIN);
   assign bus.result       = result_q;
   assign bus.result_valid = (state_q == HOLD);
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_dsp48_dot_seq.sv
// Directed bench for dsp48_dot_seq with behavioural operand memories and a
// pipelined DSP48 MAC model (A/B reg, M reg + opmode reg, P reg).
module tb_dsp48_dot_seq;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   dsp48_dot_seq_if #(.LEN_W(10), .ADDR_W(10), .NBP(48)) bus ();

   dsp48_dot_seq dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clock = ~clock;

   // ---------------- memories and DSP model ----------------
   logic signed [17:0] mem_a [0:1023];
   logic signed [17:0] mem_b [0:1023];
   logic signed [17:0] a_dout = '0, b_dout = '0, a1 = '0, b1 = '0;
   logic signed [47:0] m_q = '0, p_q = '0;
   logic [4:0]         mode_r = '0;

   always @(posedge clock) begin
      if (bus.rd_en) begin
         a_dout <= mem_a[bus.addr_a];
         b_dout <= mem_b[bus.addr_b];
      end
      if (bus.dsp_ce1) a1 <= a_dout;
      if (bus.dsp_ce2) b1 <= b_dout;
      if (bus.dsp_cem) begin
         m_q    <= a1 * b1;
         mode_r <= bus.dsp_mode;
      end
      if (bus.dsp_cep)
         p_q <= ((mode_r[3:2] == 2'b10) ? p_q : 48'sd0) + ((mode_r[1:0] == 2'b11) ? -m_q : m_q);
   end

   assign bus.dsp_p = p_q;

   // ---------------- scoreboard ----------------
   logic [9:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy"},  bus.busy, 0);
      check_eq({tag, "_rd"},    bus.rd_en, 0);
      check_eq({tag, "_addr"},  {bus.addr_a, bus.addr_b}, 0);
      check_eq({tag, "_mode"},  bus.dsp_mode, 0);
      check_eq({tag, "_ce"},    {bus.dsp_ce1, bus.dsp_ce2, bus.dsp_cem, bus.dsp_cep}, 0);
      check_eq({tag, "_res"},   bus.result, 0);
      check_eq({tag, "_valid"}, bus.result_valid, 0);
   endtask

   // Called on a negedge; drives the request immediately so back-to-back
   // requests land in the cycle after the previous handshake.
   task automatic run_op(input string tag, input int len, input int ba, input int bb,
                         input bit sub_i, input logic [47:0] exp_res, input int exp_vcyc,
                         input int ready_delay);
      int   cyc;
      int   n_rd;
      bit   got_valid;
      logic [4:0] em;
      logic [9:0] ea;
      for (int k = 0; k < len; k++) exp_q.push_back(10'(ba + k));
      bus.start        = 1'b1;
      bus.len          = 10'(len);
      bus.base_a       = 10'(ba);
      bus.base_b       = 10'(bb);
      bus.sub          = sub_i;
      bus.result_ready = (ready_delay == 0);
      cyc = 0; n_rd = 0; got_valid = 0;
      while (!got_valid && cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (cyc == 1) begin
            bus.start = 1'b0;
            check_eq({tag, "_busy1"}, bus.busy, 1);
         end
         if (bus.rd_en) begin
            n_rd++;
            check_eq({tag, "_rd_cyc"}, cyc, n_rd);
            ea = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
            check_eq({tag, "_addr_a"}, bus.addr_a, ea);
            check_eq({tag, "_addr_b"}, bus.addr_b, 10'(bb + n_rd - 1));
         end
         em = 5'b00000;
         if (cyc >= 3 && cyc <= len + 2)
            em = {1'b0, (cyc == 3) ? 2'b00 : 2'b10, sub_i ? 2'b11 : 2'b00};
         check_eq({tag, "_mode"}, bus.dsp_mode, em);
         if (bus.result_valid) got_valid = 1;
      end
      exp_q.delete();
      check_eq({tag, "_valid_cyc"}, cyc, exp_vcyc);
      check_eq({tag, "_result"}, bus.result, exp_res);
      check_eq({tag, "_rd_count"}, n_rd, len);
      check_eq({tag, "_hold_ce"}, {bus.dsp_ce1, bus.dsp_cep}, 2'b10);
      for (int d = 0; d < ready_delay; d++) begin
         if (d == 4) begin
            bus.start = 1'b1;
            bus.len   = 10'd7;
         end
         if (d == 5) bus.start = 1'b0;
         @(negedge clock);
         check_eq({tag, "_hold_res"}, bus.result, exp_res);
         check_eq({tag, "_hold_st"}, {bus.result_valid, dbg_state}, 3'b111);
      end
      bus.result_ready = 1'b1;
      @(negedge clock);
      check_eq({tag, "_post_idle"}, {bus.busy, bus.result_valid, dbg_state}, 4'b0000);
      bus.result_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 18'sd0;
         mem_b[i] = 18'sd0;
      end
      mem_a[10] = 18'sd1;  mem_a[11] = 18'sd2;  mem_a[12] = 18'sd3;  mem_a[13] = 18'sd4;
      mem_b[20] = 18'sd5;  mem_b[21] = 18'sd6;  mem_b[22] = 18'sd7;  mem_b[23] = 18'sd8;
      mem_a[30] = -18'sd3; mem_b[40] = 18'sd7;
      mem_a[1022] = 18'sd2; mem_a[1023] = -18'sd1; mem_a[0] = 18'sd3; mem_a[1] = 18'sd5;
      mem_b[100] = 18'sd4;  mem_b[101] = 18'sd6;  mem_b[102] = -18'sd2; mem_b[103] = 18'sd1;
      for (int i = 0; i < 8; i++) begin
         mem_a[200 + i] = 18'(i + 3);
         mem_b[300 + i] = 18'(i + 11);
      end
      mem_a[50] = 18'sd9; mem_a[51] = -18'sd4;
      mem_b[60] = 18'sd3; mem_b[61] = 18'sd10;

      bus.start = 1'b0; bus.len = '0; bus.base_a = '0; bus.base_b = '0;
      bus.sub = 1'b0; bus.result_ready = 1'b0;

      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      check_eq("reset_state", dbg_state, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // 1*5+2*6+3*7+4*8 = 70, valid at cycle 4+5
      run_op("dot4", 4, 10, 20, 1'b0, 48'd70, 9, 0);
      // -(-3*7) = 21, issued back-to-back
      run_op("sub1", 1, 30, 40, 1'b1, 48'd21, 6, 0);
      run_op("len0", 0, 10, 20, 1'b0, 48'd0, 1, 0);
      // 1*5+2*6+3*7 = 38, ready held off with a start pulse during HOLD
      run_op("hold", 3, 10, 20, 1'b0, 48'd38, 8, 10);
      // 2*4 + -1*6 + 3*-2 + 5*1 = 1, addr_a 1022,1023,0,1
      run_op("wrap", 4, 1022, 100, 1'b0, 48'd1, 9, 0);

      // abort a len=8 op mid-ISSUE
      bus.start = 1'b1; bus.len = 10'd8; bus.base_a = 10'd200; bus.base_b = 10'd300;
      bus.sub = 1'b0;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("abort_pre", {bus.rd_en, dbg_state}, 3'b101);
      #2 reset_n = 1'b0;
      #1 check_idle_outputs("abort");
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // 9*3 + -4*10 = -13
      run_op("after_rst", 2, 50, 60, 1'b0, 48'hFFFF_FFFF_FFF3, 7, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
